// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Holds the hex glyph table, segment bit positions, the all-off pattern and scan states.
package seg7_pkg;

  // Segment positions on the 8-bit bus: seg[7:1] = a..g, seg[0] = decimal point.
  localparam int unsigned SEG_A_BIT  = 7;
  localparam int unsigned SEG_G_BIT  = 1;
  localparam int unsigned SEG_DP_BIT = 0;

  // All segments dark, in active-high sense; output polarity is applied later.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Hex digit to abcdefg, bit 6 = a ... bit 0 = g.
  localparam logic [6:0] HEX_TO_SEG [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to abcdefg segment pattern (active-high).
module seg7_hex_decode (
  input  logic [3:0] hex,
  output logic [6:0] abcdefg
);
  import seg7_pkg::*;

  // Plain table lookup so the glyph set lives only in the package.
  always_comb begin
    abcdefg = HEX_TO_SEG[hex];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous double buffering.
// Each digit is lit for SCAN_DIV clocks; new content only switches in at frame boundaries
// (or immediately while idle), so a frame never shows a mix of old and new digits.
// Optional blink support is compiled in with `define SEG7_SCAN_BLINK_EN.
module seg7_scan_driver #(
  parameter int unsigned N_DIGITS     = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter bit          ACTIVE_LOW   = 1'b0
`ifdef SEG7_SCAN_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_in,
`endif
  output logic [7:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done,
  output logic                  pending
);
  import seg7_pkg::*;

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
  localparam logic [PRE_W-1:0]    LAST_PRE = PRE_W'(SCAN_DIV - 1);
  localparam logic [7:0]          SEG_POL  = {8{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_POL   = {N_DIGITS{ACTIVE_LOW}};

  // Scan sequencing
  scan_state_e      state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick;

  // Display (what is shown) and shadow (what is waiting) buffers
  logic [N_DIGITS-1:0][3:0] disp_dig_q, shadow_dig_q;
  logic [N_DIGITS-1:0]      disp_dp_q, shadow_dp_q;
  logic [N_DIGITS-1:0]      disp_blank_q, shadow_blank_q;
  logic                     pending_q;
  logic                     transfer;

  // Rendering
  logic [N_DIGITS-1:0] eff_blank;
  logic [3:0]          cur_hex;
  logic [6:0]          cur_abcdefg;
  logic [7:0]          seg_raw;
  logic [N_DIGITS-1:0] an_raw;
  logic [7:0]          seg_q;
  logic [N_DIGITS-1:0] an_q;

  // State, prescaler and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: idle holds counters at zero, scan steps the prescaler and digit index.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    idx_d      = idx_q;
    tick       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StIdle: begin
        presc_d = '0;
        idx_d   = '0;
        if (en) begin
          state_d = StScan;
        end
      end
      StScan: begin
        tick       = (presc_q == LAST_PRE);
        frame_done = tick && (idx_q == LAST_IDX);
        if (tick) begin
          presc_d = '0;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // Dropping en abandons the partial frame.
        if (!en) begin
          state_d = StIdle;
          presc_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Shadow copies into the display at a frame edge, or at once while idle.
  assign transfer = frame_done || (state_q == StIdle);

  // Double-buffer update; a load coinciding with a transfer bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_dig_q     <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= '1;
      shadow_dig_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '1;
      pending_q      <= 1'b0;
    end else if (load && transfer) begin
      disp_dig_q   <= din;
      disp_dp_q    <= dp_in;
      disp_blank_q <= blank_in;
      pending_q    <= 1'b0;
    end else if (transfer) begin
      if (pending_q) begin
        disp_dig_q   <= shadow_dig_q;
        disp_dp_q    <= shadow_dp_q;
        disp_blank_q <= shadow_blank_q;
      end
      pending_q <= 1'b0;
    end else if (load) begin
      shadow_dig_q   <= din;
      shadow_dp_q    <= dp_in;
      shadow_blank_q <= blank_in;
      pending_q      <= 1'b1;
    end
  end

  assign pending = pending_q;

`ifdef SEG7_SCAN_BLINK_EN
  localparam int unsigned          BCNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BCNT_W-1:0]    BCNT_LAST = BCNT_W'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0] disp_blink_q, shadow_blink_q;
  logic [BCNT_W-1:0]   bcnt_q;
  logic                phase_on_q;

  // Blink mask follows exactly the same double-buffer rules as the other per-digit masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_blink_q   <= '0;
      shadow_blink_q <= '0;
    end else if (load && transfer) begin
      disp_blink_q <= blink_in;
    end else if (transfer) begin
      if (pending_q) begin
        disp_blink_q <= shadow_blink_q;
      end
    end else if (load) begin
      shadow_blink_q <= blink_in;
    end
  end

  // Frame counter: flips the blink phase every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q     <= '0;
      phase_on_q <= 1'b1;
    end else if (frame_done) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_q     <= '0;
        phase_on_q <= ~phase_on_q;
      end else begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  assign eff_blank = disp_blank_q | (disp_blink_q & {N_DIGITS{~phase_on_q}});
`else
  assign eff_blank = disp_blank_q;
`endif

  assign cur_hex = disp_dig_q[idx_q];

  seg7_hex_decode u_hex_decode (
    .hex     (cur_hex),
    .abcdefg (cur_abcdefg)
  );

  // Active-high pattern for the current slot; dark when idle or the digit is blanked.
  always_comb begin
    seg_raw = SEG_OFF;
    an_raw  = '0;
    if ((state_q == StScan) && !eff_blank[idx_q]) begin
      seg_raw[SEG_A_BIT:SEG_G_BIT] = cur_abcdefg;
      seg_raw[SEG_DP_BIT]          = disp_dp_q[idx_q];
      an_raw[idx_q]                = 1'b1;
    end
  end

  // Output registers with board polarity folded in; reset forces the dark pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_OFF ^ SEG_POL;
      an_q  <= AN_POL;
    end else begin
      seg_q <= seg_raw ^ SEG_POL;
      an_q  <= an_raw ^ AN_POL;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N_DIGITS=4, SCAN_DIV=4), with an
// active-high and an active-low instance driven from the same stimulus.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;
  localparam int BF    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  blink_src;
`ifdef SEG7_SCAN_BLINK_EN
  logic [3:0]  blink_in = '0;
  assign blink_src = blink_in;
`else
  assign blink_src = 4'b0000;
`endif

  logic [7:0] seg, seg_al;
  logic [3:0] an, an_al;
  logic       fd, fd_al, pend, pend_al;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS     (N),
    .SCAN_DIV     (DIV),
    .ACTIVE_LOW   (1'b0)
`ifdef SEG7_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
`ifdef SEG7_SCAN_BLINK_EN
    .blink_in   (blink_in),
`endif
    .seg        (seg),
    .an         (an),
    .frame_done (fd),
    .pending    (pend)
  );

  seg7_scan_driver #(
    .N_DIGITS     (N),
    .SCAN_DIV     (DIV),
    .ACTIVE_LOW   (1'b1)
`ifdef SEG7_SCAN_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut_al (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
`ifdef SEG7_SCAN_BLINK_EN
    .blink_in   (blink_in),
`endif
    .seg        (seg_al),
    .an         (an_al),
    .frame_done (fd_al),
    .pending    (pend_al)
  );

  // Glyph table abcdefg for 0..F.
  logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Reference model: time since scan start m_t gives slot (m_t/DIV)%N and frame end.
  bit          m_scan = 1'b0;
  int          m_t = 0;
  logic [15:0] m_dig = '0, s_dig = '0;
  logic [3:0]  m_dp = '0, s_dp = '0, m_bk = '1, s_bk = '1, m_bl = '0, s_bl = '0;
  bit          m_pend = 1'b0;
  logic [7:0]  m_seg = '0;
  logic [3:0]  m_an = '0;
  int          m_bcnt = 0;
  bit          m_bon = 1'b1;

  function automatic bit m_fd();
    return m_scan && ((m_t % FRAME) == FRAME - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit fdn;
    bit xfer;
    int d;
    bit dark;
    if (!rst_n) begin
      m_scan = 1'b0; m_t = 0; m_pend = 1'b0; m_seg = '0; m_an = '0;
      m_dig = '0; m_dp = '0; m_bk = '1; m_bl = '0;
      s_dig = '0; s_dp = '0; s_bk = '1; s_bl = '0;
      m_bcnt = 0; m_bon = 1'b1;
    end else begin
      fdn  = m_fd();
      xfer = fdn || !m_scan;
      d    = (m_t / DIV) % N;
      dark = m_bk[d] || (m_bl[d] && !m_bon);
      if (m_scan && !dark) begin
        m_seg = {hex_tab[m_dig[4*d +: 4]], m_dp[d]};
        m_an  = 4'(1 << d);
      end else begin
        m_seg = '0;
        m_an  = '0;
      end
      if (load && xfer) begin
        m_dig = din; m_dp = dp_in; m_bk = blank_in; m_bl = blink_src; m_pend = 1'b0;
      end else if (xfer) begin
        if (m_pend) begin
          m_dig = s_dig; m_dp = s_dp; m_bk = s_bk; m_bl = s_bl;
        end
        m_pend = 1'b0;
      end else if (load) begin
        s_dig = din; s_dp = dp_in; s_bk = blank_in; s_bl = blink_src; m_pend = 1'b1;
      end
      if (fdn) begin
        m_bcnt++;
        if (m_bcnt == BF) begin
          m_bcnt = 0;
          m_bon  = !m_bon;
        end
      end
      if (!m_scan) begin
        m_scan = en;
        m_t    = 0;
      end else if (!en) begin
        m_scan = 1'b0;
        m_t    = 0;
      end else begin
        m_t++;
      end
    end
  end

  task automatic test_reset();
    en = 1'b1; load = 1'b1; din = 16'h1234; dp_in = '0; blank_in = '0;
    @(negedge clk); load = 1'b0;
    repeat (9) @(negedge clk);
    load = 1'b1; din = 16'h5555;
    @(negedge clk); load = 1'b0;
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rst_pre_pend got %b exp 1", pend); end
    checks++; if (an !== 4'b0100) begin errors++; $display("FAIL rst_pre_an got %b exp 0100", an); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (seg !== 8'h00) begin errors++; $display("FAIL rst_seg got %h exp 00", seg); end
    checks++; if (an !== 4'h0) begin errors++; $display("FAIL rst_an got %b exp 0000", an); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL rst_pend got %b exp 0", pend); end
    checks++; if (fd !== 1'b0) begin errors++; $display("FAIL rst_fd got %b exp 0", fd); end
    checks++; if (seg_al !== 8'hFF) begin errors++; $display("FAIL rst_seg_al got %h exp ff", seg_al); end
    checks++; if (an_al !== 4'hF) begin errors++; $display("FAIL rst_an_al got %b exp 1111", an_al); end
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (seg !== 8'h00) begin errors++; $display("FAIL rel_seg got %h exp 00", seg); end
      checks++; if (an !== 4'h0) begin errors++; $display("FAIL rel_an got %b exp 0000", an); end
    end
  endtask

  task automatic test_idle_scan();
    logic [7:0] exp_a [4] = '{8'h8E, 8'hE0, 8'hEE, 8'hF2};
    int waited = 0;
    int pulses = 0;
    load = 1'b1; din = 16'h3A7F; dp_in = '0; blank_in = '0;
    @(negedge clk); load = 1'b0;
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL idle_load_pend got %b exp 0", pend); end
    en = 1'b1;
    while (an === 4'h0 && waited < 10) begin @(negedge clk); waited++; end
    checks++; if (waited != 2) begin errors++; $display("FAIL scan_latency got %0d exp 2", waited); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (an !== 4'(1 << (k / 4))) begin
        errors++; $display("FAIL scan_an k=%0d got %b exp %b", k, an, 4'(1 << (k / 4)));
      end
      checks++;
      if (seg !== exp_a[k / 4]) begin
        errors++; $display("FAIL scan_seg k=%0d got %h exp %h", k, seg, exp_a[k / 4]);
      end
      if (fd === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL fd_count got %0d exp 1", pulses); end
  endtask

  task automatic test_mid_frame_load();
    logic [7:0] exp_a [4] = '{8'h8E, 8'hE0, 8'hEE, 8'hF2};
    int lim = 0;
    while (an !== 4'b0010 && lim < 40) begin @(negedge clk); lim++; end
    load = 1'b1; din = 16'h0000; dp_in = '0; blank_in = '0;
    @(negedge clk); load = 1'b0;
    lim = 0;
    while (fd !== 1'b1 && lim < 40) begin
      checks++; if (pend !== 1'b1) begin errors++; $display("FAIL mid_pend got %b exp 1", pend); end
      checks++;
      if (seg !== exp_a[$clog2(an)]) begin
        errors++; $display("FAIL mid_hold got %h exp %h", seg, exp_a[$clog2(an)]);
      end
      @(negedge clk); lim++;
    end
    checks++; if (lim >= 40) begin errors++; $display("FAIL mid_fd_timeout got %0d exp <40", lim); end
    @(negedge clk);
    checks++; if (seg !== 8'hF2) begin errors++; $display("FAIL mid_tail got %h exp f2", seg); end
    checks++; if (an !== 4'b1000) begin errors++; $display("FAIL mid_tail_an got %b exp 1000", an); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL mid_clear got %b exp 0", pend); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (seg !== 8'hFC) begin errors++; $display("FAIL mid_new got %h exp fc", seg); end
      checks++;
      if (an !== 4'(1 << (k / 4))) begin
        errors++; $display("FAIL mid_new_an got %b exp %b", an, 4'(1 << (k / 4)));
      end
    end
  endtask

  task automatic test_load_at_frame_done();
    int lim = 0;
    while (fd !== 1'b1 && lim < 40) begin @(negedge clk); lim++; end
    checks++; if (lim >= 40) begin errors++; $display("FAIL coin_fd_timeout got %0d exp <40", lim); end
    load = 1'b1; din = 16'h8888; dp_in = '0; blank_in = '0;
    @(negedge clk); load = 1'b0;
    checks++; if (seg !== 8'hFC) begin errors++; $display("FAIL coin_tail got %h exp fc", seg); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL coin_pend0 got %b exp 0", pend); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (seg !== 8'hFE) begin errors++; $display("FAIL coin_seg got %h exp fe", seg); end
      checks++; if (pend !== 1'b0) begin errors++; $display("FAIL coin_pend got %b exp 0", pend); end
    end
  endtask

  task automatic test_masks();
    logic [7:0] exp_s [4] = '{8'h66, 8'hF3, 8'h00, 8'h60};
    logic [3:0] exp_n [4] = '{4'b0001, 4'b0010, 4'b0000, 4'b1000};
    int lim = 0;
    while (an !== 4'b0001 && lim < 40) begin @(negedge clk); lim++; end
    load = 1'b1; din = 16'h1234; dp_in = 4'b0010; blank_in = 4'b0100;
    @(negedge clk); load = 1'b0;
    lim = 0;
    while (fd !== 1'b1 && lim < 40) begin @(negedge clk); lim++; end
    checks++; if (lim >= 40) begin errors++; $display("FAIL mask_fd_timeout got %0d exp <40", lim); end
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_s[k / 4]) begin
        errors++; $display("FAIL mask_seg k=%0d got %h exp %h", k, seg, exp_s[k / 4]);
      end
      checks++;
      if (an !== exp_n[k / 4]) begin
        errors++; $display("FAIL mask_an k=%0d got %b exp %b", k, an, exp_n[k / 4]);
      end
      checks++;
      if (seg_al !== ~exp_s[k / 4]) begin
        errors++; $display("FAIL mask_seg_al k=%0d got %h exp %h", k, seg_al, ~exp_s[k / 4]);
      end
      checks++;
      if (an_al !== ~exp_n[k / 4]) begin
        errors++; $display("FAIL mask_an_al k=%0d got %b exp %b", k, an_al, ~exp_n[k / 4]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lim = 0;
    while (an !== 4'b0001 && lim < 40) begin @(negedge clk); lim++; end
    load = 1'b1; din = 16'h1111; dp_in = '0; blank_in = '0;
    @(negedge clk); din = 16'h2222;
    @(negedge clk); load = 1'b0;
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL b2b_pend got %b exp 1", pend); end
    lim = 0;
    while (fd !== 1'b1 && lim < 40) begin @(negedge clk); lim++; end
    checks++; if (lim >= 40) begin errors++; $display("FAIL b2b_fd_timeout got %0d exp <40", lim); end
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (seg !== 8'hDA) begin errors++; $display("FAIL b2b_seg got %h exp da", seg); end
      checks++; if (pend !== 1'b0) begin errors++; $display("FAIL b2b_pend0 got %b exp 0", pend); end
    end
  endtask

`ifdef SEG7_SCAN_BLINK_EN
  task automatic test_blink();
    bit lit;
    @(negedge clk); rst_n = 1'b0; en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    load = 1'b1; din = 16'h0000; dp_in = '0; blank_in = '0; blink_in = 4'b0001; en = 1'b1;
    @(negedge clk); load = 1'b0; blink_in = '0;
    for (int f = 0; f < 6; f++) begin
      lit = !(f == 2 || f == 3);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (k / 4 == 0) begin
          checks++;
          if (an !== (lit ? 4'b0001 : 4'b0000)) begin
            errors++; $display("FAIL blink_an f=%0d got %b exp lit=%0d", f, an, lit);
          end
          checks++;
          if (seg !== (lit ? 8'hFC : 8'h00)) begin
            errors++; $display("FAIL blink_seg f=%0d got %h exp lit=%0d", f, seg, lit);
          end
        end else begin
          checks++;
          if (an !== 4'(1 << (k / 4))) begin
            errors++; $display("FAIL blink_other f=%0d got %b exp %b", f, an, 4'(1 << (k / 4)));
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++; if (seg !== m_seg) begin errors++; $display("FAIL rnd_seg i=%0d got %h exp %h", i, seg, m_seg); end
      checks++; if (an !== m_an) begin errors++; $display("FAIL rnd_an i=%0d got %b exp %b", i, an, m_an); end
      checks++; if (fd !== m_fd()) begin errors++; $display("FAIL rnd_fd i=%0d got %b exp %b", i, fd, m_fd()); end
      checks++; if (pend !== m_pend) begin errors++; $display("FAIL rnd_pend i=%0d got %b exp %b", i, pend, m_pend); end
      checks++;
      if (seg_al !== ~m_seg) begin errors++; $display("FAIL rnd_seg_al i=%0d got %h exp %h", i, seg_al, ~m_seg); end
      checks++;
      if (an_al !== ~m_an) begin errors++; $display("FAIL rnd_an_al i=%0d got %b exp %b", i, an_al, ~m_an); end
      checks++;
      if (fd_al !== m_fd()) begin errors++; $display("FAIL rnd_fd_al i=%0d got %b exp %b", i, fd_al, m_fd()); end
      checks++;
      if (pend_al !== m_pend) begin errors++; $display("FAIL rnd_pend_al i=%0d got %b exp %b", i, pend_al, m_pend); end
      en       = ($urandom_range(0, 39) != 0);
      load     = ($urandom_range(0, 7) == 0);
      din      = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_in = 4'($urandom) & 4'($urandom);
`ifdef SEG7_SCAN_BLINK_EN
      blink_in = 4'($urandom);
`endif
    end
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_idle_scan();
    test_mid_frame_load();
    test_load_at_frame_done();
    test_masks();
    test_back_to_back();
`ifdef SEG7_SCAN_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Multi-digit, time-multiplexed seven-segment display driver. It is the parametrised successor of the single-digit BCD decoder: full hex decode (0-F), per-digit decimal point and blanking, and double-buffered loading that switches content only at frame boundaries, so the display never tears. It sits between a value source (counters, register views) and the board's shared segment bus and per-digit anode lines.

Parameters:
N_DIGITS, 8, number of digits scanned; legal range 1..16.
SCAN_DIV, 1000, clk cycles each digit stays active; must be >= 2.
ACTIVE_LOW, 0, 1 inverts both seg and an at the output registers.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
en  in  1  1 = scanning; 0 = idle, all digits off
load  in  1  single-cycle strobe; captures din, dp_in and blank_in
din  in  4*N_DIGITS  hex nibbles; din[3:0] is digit 0 (rightmost)
dp_in  in  N_DIGITS  decimal-point enable per digit
blank_in  in  N_DIGITS  1 = digit dark
seg  out  8  seg[7:1] = a..g, seg[0] = dp (active-high when ACTIVE_LOW=0)
an  out  N_DIGITS  one-hot digit enable
frame_done  out  1  one-cycle pulse at the end of each full scan
pending  out  1  1 = loaded data is waiting for a frame boundary

Behaviour:
- Reset (async, rst_n=0):
  - seg = all off (8'h00, or 8'hFF if ACTIVE_LOW=1); an = all off.
  - frame_done = 0; pending = 0.
  - Prescaler and digit index = 0.
  - Display buffer: digits = 0, dp = 0, blank = all 1s.
  - Outputs change without waiting for a clock edge.
- State machine, two states:
  - IDLE: entered from reset, or when en=0.
    - Prescaler and index held at 0; seg and an all off; frame_done = 0.
    - On en=1, go to SCAN on the next cycle.
  - SCAN:
    - Prescaler counts 0..SCAN_DIV-1. tick = prescaler at SCAN_DIV-1.
    - On tick, index advances and wraps from N_DIGITS-1 to 0. frame_done pulses for that cycle (tick with index = N_DIGITS-1).
    - en=0 at any point: return to IDLE the next cycle, abandoning the partial frame.
- Outputs:
  - seg and an are registered, one cycle behind the index.
  - an = one-hot(index).
  - seg = decode(display digit[index]) with seg[0] = dp[index].
  - A blanked digit drives seg off and its an off.
- Decode table for seg[7:1], abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Double buffer:
  - load writes a shadow buffer and sets pending=1.
  - A load while pending is already 1 overwrites the shadow; last load wins.
  - Transfer shadow -> display happens on a frame_done cycle, or on any cycle in IDLE. Transfer clears pending.
  - load in the same cycle as a transfer: din, dp_in and blank_in go directly into the display buffer and pending stays 0.
- Index width is max(1, $clog2(N_DIGITS)). With N_DIGITS=1, frame_done pulses on every tick.

Optional Feature:
- Macro: SEG7_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_in [N_DIGITS] (double-buffered like dp_in) and parameter BLINK_FRAMES, default 64.
  - A frame counter toggles a blink phase every BLINK_FRAMES frame_done pulses.
  - During the off phase, digits with blink set are treated as blanked.
  - Reset sets the phase to on and the counter to 0.
- Undefined: no port, no parameter, no counter; behaviour exactly as above.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-abcdefg constant table
  - SEG_OFF
  - segment bit-position constants
  - the scan state enum (IDLE, SCAN)
- Sub-module: seg7_hex_decode, combinational 4-bit -> 7-bit decode, instantiated once on the selected digit.

Test Plan:
All scenarios use N_DIGITS=4, SCAN_DIV=4 unless stated.
1. Reset: rst_n=0 mid-SCAN, no clk edge -> seg=8'h00, an=4'b0000, pending=0 immediately. Release with en=0 -> outputs stay off.
2. Idle load then scan: en=0, load din=16'h3A7F, dp_in=0, blank_in=0; then en=1 -> an=0001 seg=8'h8E (4 cycles), an=0010 seg=8'hE0, an=0100 seg=8'hEE, an=1000 seg=8'hF2. frame_done pulses once per 16 cycles.
3. Mid-frame load: during digit 1, load din=16'h0000 -> pending=1 and display unchanged until frame_done. Next frame shows seg=8'hFC on all digits and pending=0.
4. Load coincident with frame_done: load 16'h8888 -> next frame shows seg=8'hFE on all digits; pending never rises.
5. Masks: blank_in=4'b0100, dp_in=4'b0010 -> digit 2 slot has an=0000 and seg=8'h00; digit 1 has seg[0]=1. Repeat with ACTIVE_LOW=1 -> seg and an bitwise inverted.
6. SEG7_SCAN_BLINK_EN defined, BLINK_FRAMES=2, blink_in=4'b0001 -> digit 0 dark for frames 2-3 and lit for frames 0-1 and 4-5; the other digits are unaffected.
